// File: rtl/serial_frame_tx.sv
// Purpose : serialises one WIDTH-bit word per frame, LSB first: start(0), data, optional parity, stop(1).
// Latency : tx falls on the acceptance edge; the frame lasts (2+WIDTH+PARITY_EN)*DIV clocks, then done pulses once.
// Backpr. : A_ready is high only in IDLE; A_valid is ignored at all other times, so the source simply holds its word.
//
// Ports:
//   CLK      rising-edge clock
//   Clear    synchronous active-high reset; aborts any frame in flight without a done pulse
//   A_par    word to transmit, sampled only on the accepting edge
//   A_valid  A_par holds a word
//   A_ready  block can accept a word (registered, high in IDLE)
//   tx       serial line, idles high (registered)
//   busy     frame in progress, START..STOP (registered)
//   done     one-cycle pulse in the first IDLE cycle after a completed frame (registered)
module serial_frame_tx #(
  parameter int WIDTH      = 4,
  parameter int DIV        = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic [WIDTH-1:0] A_par,
  input  logic             A_valid,
  output logic             A_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = $clog2(DIV) + 1;
  localparam int BIT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             r_state, w_state;
  logic [DIV_W-1:0]   r_div, w_div;
  logic [BIT_W-1:0]   r_bitcnt, w_bitcnt;
  logic [WIDTH-1:0]   r_shreg, w_shreg;
  logic               r_parity, w_parity;
  logic               r_tx, w_tx;
  logic               r_ready, w_ready;
  logic               r_busy, w_busy;
  logic               r_done, w_done;

  logic               w_bit_end;
  logic               w_last_bit;
  logic [WIDTH-1:0]   w_shifted;

  assign w_bit_end  = (r_div == DIV_W'(DIV - 1));
  assign w_last_bit = (r_bitcnt == BIT_W'(WIDTH - 1));
  // The next data bit always sits in bit 0 after the shift; reading it this
  // way keeps WIDTH=1 legal.
  assign w_shifted  = r_shreg >> 1;

  always_ff @(posedge CLK) begin
    if (Clear) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_div    <= w_div;
      r_bitcnt <= w_bitcnt;
      r_shreg  <= w_shreg;
      r_parity <= w_parity;
      r_tx     <= w_tx;
      r_ready  <= w_ready;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_div    = r_div;
    w_bitcnt = r_bitcnt;
    w_shreg  = r_shreg;
    w_parity = r_parity;
    w_tx     = r_tx;
    w_ready  = r_ready;
    w_busy   = r_busy;
    w_done   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (A_valid && r_ready) begin
          w_state  = S_START;
          w_shreg  = A_par;
          w_parity = (PARITY_ODD != 0) ? ~(^A_par) : ^A_par;
          w_div    = '0;
          w_bitcnt = '0;
          w_tx     = 1'b0;
          w_ready  = 1'b0;
          w_busy   = 1'b1;
        end
      end

      S_START: begin
        if (w_bit_end) begin
          w_state = S_DATA;
          w_div   = '0;
          w_tx    = r_shreg[0];
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_div = '0;
          if (w_last_bit) begin
            w_bitcnt = '0;
            if (PARITY_EN != 0) begin
              w_state = S_PARITY;
              w_tx    = r_parity;
            end else begin
              w_state = S_STOP;
              w_tx    = 1'b1;
            end
          end else begin
            w_bitcnt = r_bitcnt + BIT_W'(1);
            w_shreg  = w_shifted;
            w_tx     = w_shifted[0];
          end
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          w_state = S_STOP;
          w_div   = '0;
          w_tx    = 1'b1;
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_state = S_IDLE;
          w_div   = '0;
          w_tx    = 1'b1;
          w_ready = 1'b1;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end

      default: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign A_ready = r_ready;
  assign tx      = r_tx;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: instance A (WIDTH=4, DIV=4, even parity) and
// instance B (WIDTH=4, DIV=1, no parity) share the clock and Clear.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic [3:0] a_par, b_par;
  logic       a_valid, b_valid;
  logic       a_ready, a_tx, a_busy, a_done;
  logic       b_ready, b_tx, b_busy, b_done;

  serial_frame_tx #(.WIDTH(4), .DIV(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
    .CLK(clk), .Clear(clr), .A_par(a_par), .A_valid(a_valid),
    .A_ready(a_ready), .tx(a_tx), .busy(a_busy), .done(a_done)
  );

  serial_frame_tx #(.WIDTH(4), .DIV(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_b (
    .CLK(clk), .Clear(clr), .A_par(b_par), .A_valid(b_valid),
    .A_ready(b_ready), .tx(b_tx), .busy(b_busy), .done(b_done)
  );

  // Expected per-cycle observation {tx, done, ready, busy}
  typedef struct packed {
    logic tx;
    logic done;
    logic rdy;
    logic busy;
  } exp_t;

  typedef struct {
    logic [3:0] word;
    logic       par;
  } vec_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got {tx,done,rdy,busy}=%b expected %b", name, idx, act, exp);
    end
  endtask

  function automatic void push_n(input int n, input logic t);
    exp_t e;
    e = {t, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < n; c++) q.push_back(e);
  endfunction

  // Frame bit list; parity comes from the caller's table, not computed here.
  function automatic void push_frame(input bit sel, input logic [3:0] w, input logic par);
    int div;
    div = sel ? 1 : 4;
    push_n(div, 1'b0);
    for (int b = 0; b < 4; b++) push_n(div, w[b]);
    if (!sel) push_n(div, par);
    push_n(div, 1'b1);
  endfunction

  function automatic void push_done();
    q.push_back(4'b1110);
  endfunction

  function automatic void push_idle();
    q.push_back(4'b1010);
  endfunction

  // Pops one expectation per cycle (sampled at negedge) and applies the
  // requested mid-stream input changes.
  task automatic drain(input string name, input bit sel, input int drop_at,
                       input int par_at, input logic [3:0] par_val, input int pulse_at);
    int n;
    exp_t e;
    n = q.size();
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      e = q.pop_front();
      chk(name, j, sel ? {b_tx, b_done, b_ready, b_busy} : {a_tx, a_done, a_ready, a_busy}, e);
      if (j == drop_at) begin
        if (sel) b_valid = 1'b0;
        else     a_valid = 1'b0;
      end
      if (j == par_at) begin
        if (sel) b_par = par_val;
        else     a_par = par_val;
      end
      if (pulse_at >= 0 && j == pulse_at) begin
        if (sel) b_valid = 1'b1;
        else     a_valid = 1'b1;
      end
      if (pulse_at >= 0 && j == pulse_at + 2) begin
        if (sel) b_valid = 1'b0;
        else     a_valid = 1'b0;
      end
    end
  endtask

  vec_t tbl_a[6];
  vec_t tbl_b[4];

  initial begin
    tbl_a[0] = '{4'b1011, 1'b1};
    tbl_a[1] = '{4'b0000, 1'b0};
    tbl_a[2] = '{4'b1111, 1'b0};
    tbl_a[3] = '{4'b0001, 1'b1};
    tbl_a[4] = '{4'b0110, 1'b0};
    tbl_a[5] = '{4'b1000, 1'b1};
    tbl_b[0] = '{4'b0000, 1'b0};
    tbl_b[1] = '{4'b1111, 1'b0};
    tbl_b[2] = '{4'b1010, 1'b0};
    tbl_b[3] = '{4'b0011, 1'b0};

    // Reset held two clocks with valid high: nothing may be accepted.
    clr = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_par = 4'hF; b_par = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_a", i, {a_tx, a_done, a_ready, a_busy}, 4'b1010);
      chk("reset_b", i, {b_tx, b_done, b_ready, b_busy}, 4'b1010);
    end
    clr = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_a", 0, {a_tx, a_done, a_ready, a_busy}, 4'b1010);
    chk("post_reset_b", 0, {b_tx, b_done, b_ready, b_busy}, 4'b1010);

    // Instance A table; entry 2 also gets a stray valid pulse mid-frame,
    // and every entry sees A_par change mid-frame.
    for (int i = 0; i < 6; i++) begin
      a_par = tbl_a[i].word; a_valid = 1'b1;
      push_frame(1'b0, tbl_a[i].word, tbl_a[i].par);
      push_done();
      push_idle();
      drain("frame_a", 1'b0, 0, 5, ~tbl_a[i].word, (i == 2) ? 10 : -1);
    end

    // Instance B table: DIV=1, no parity, 6-cycle frames.
    for (int i = 0; i < 4; i++) begin
      b_par = tbl_b[i].word; b_valid = 1'b1;
      push_frame(1'b1, tbl_b[i].word, 1'b0);
      push_done();
      push_idle();
      drain("frame_b", 1'b1, 0, 2, ~tbl_b[i].word, -1);
    end

    // Back-to-back on A: valid held high, second word taken in the done cycle.
    a_par = 4'hA; a_valid = 1'b1;
    push_frame(1'b0, 4'hA, 1'b0);
    push_done();
    push_frame(1'b0, 4'h5, 1'b0);
    push_done();
    push_idle();
    drain("b2b_a", 1'b0, 29, 5, 4'h5, -1);

    // Clear during DATA bit 2 of A: immediate abort, no done pulse.
    a_par = 4'b0110; a_valid = 1'b1;
    push_frame(1'b0, 4'b0110, 1'b0);
    while (q.size() > 13) void'(q.pop_back());
    drain("abort_pre", 1'b0, 0, -1, 4'h0, -1);
    clr = 1'b1;
    @(negedge clk);
    chk("abort_now", 0, {a_tx, a_done, a_ready, a_busy}, 4'b1010);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", i, {a_tx, a_done, a_ready, a_busy}, 4'b1010);
    end

    // New word after the abort transmits normally.
    a_par = 4'b1001; a_valid = 1'b1;
    push_frame(1'b0, 4'b1001, 1'b0);
    push_done();
    push_idle();
    drain("after_abort", 1'b0, 0, -1, 4'h0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
